// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

  typedef logic [1:0] digit_idx_t;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
  localparam logic                  DP_OFF = 1'b1;

endpackage

// File: rtl/seg_display_scanner_refresh_prescaler.sv
// Dwell counter for the display scan: wraps every DWELL cycles and flags the
// anti-ghosting guard window at the start of each dwell.
module refresh_prescaler #(
  parameter int unsigned DWELL = 65536,
  parameter int unsigned GUARD = 256
) (
  input  logic clk,
  input  logic reset,
  output logic at_zero_c,
  output logic wrap_c,
  output logic in_guard_c
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (wrap_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    at_zero_c  = (cnt == '0);
    wrap_c     = (cnt == CW'(DWELL - 1));
    in_guard_c = (cnt < CW'(GUARD));
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Latches the display data once per frame and emits registered digit signals.
module seg_display_scanner
  import disp_pkg::*;
#(
  parameter int unsigned DWELL = 65536,
  parameter int unsigned GUARD = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dig_en,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  lz_blank,
  output logic [NIB_W-1:0]      nibble,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic [1:0]            digit_sel,
  output logic                  frame_done
);

  logic at_zero_c;
  logic wrap_c;
  logic in_guard_c;

  refresh_prescaler #(
    .DWELL (DWELL),
    .GUARD (GUARD)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .at_zero_c  (at_zero_c),
    .wrap_c     (wrap_c),
    .in_guard_c (in_guard_c)
  );

  digit_idx_t            d;
  logic [VALUE_W-1:0]    sh_value;
  logic [NUM_DIGITS-1:0] sh_en;
  logic [NUM_DIGITS-1:0] sh_dp;
  logic                  sh_lz;

  logic [NIB_W-1:0]      nib_c;
  logic [NUM_DIGITS-1:0] lz_ok_c;
  logic                  lit_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic                  dp_c;
  logic                  load_c;
  logic                  frame_end_c;

  // Digit select, LZ mask and anode decode from the current scan state.
  always_comb begin
    nib_c       = '0;
    lz_ok_c     = '1;
    lit_c       = 1'b0;
    an_c        = AN_OFF;
    dp_c        = DP_OFF;
    load_c      = at_zero_c && (d == 2'd0);
    frame_end_c = wrap_c && (d == 2'd3);

    case (d)
      2'd0:    nib_c = sh_value[3:0];
      2'd1:    nib_c = sh_value[7:4];
      2'd2:    nib_c = sh_value[11:8];
      default: nib_c = sh_value[15:12];
    endcase

    // A digit survives blanking if it or any more significant nibble is nonzero.
    if (sh_lz) begin
      lz_ok_c[0] = 1'b1;
      lz_ok_c[1] = |sh_value[15:4];
      lz_ok_c[2] = |sh_value[15:8];
      lz_ok_c[3] = |sh_value[15:12];
    end

    lit_c = !in_guard_c && sh_en[d] && lz_ok_c[d];
    if (lit_c) begin
      an_c = ~(NUM_DIGITS'(1) << d);
      dp_c = ~sh_dp[d];
    end
  end

  // Scan index, frame shadow and output registers share one edge; the stale
  // shadow seen on the load edge falls inside the guard window.
  always_ff @(posedge clk) begin
    if (reset) begin
      d          <= '0;
      sh_value   <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      nibble     <= '0;
      an         <= AN_OFF;
      dp         <= DP_OFF;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (wrap_c) begin
        d <= d + 2'd1;
      end
      if (load_c) begin
        sh_value <= value;
        sh_en    <= dig_en;
        sh_dp    <= dp_in;
        sh_lz    <= lz_blank;
      end
      nibble     <= nib_c;
      an         <= an_c;
      dp         <= dp_c;
      digit_sel  <= d;
      frame_done <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with DWELL=8, GUARD=2; cycle k counts
// from the first post-reset cycle and outputs are sampled on the falling edge.
module tb_seg_display_scanner;

  localparam int unsigned DWELL = 8;
  localparam int unsigned GUARD = 2;
  localparam int unsigned FRAME = 4 * DWELL;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dig_en;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int kk       = 0;

  seg_display_scanner #(
    .DWELL (DWELL),
    .GUARD (GUARD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dig_en     (dig_en),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .nibble     (nibble),
    .an         (an),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got %h, expected %h", tag, kk, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_an",  16'(an),         16'hF);
    chk("rst_dp",  16'(dp),         16'h1);
    chk("rst_nib", 16'(nibble),     16'h0);
    chk("rst_sel", 16'(digit_sel),  16'h0);
    chk("rst_fd",  16'(frame_done), 16'h0);
  endtask

  // Holds reset for n edges; returns on the falling edge of cycle k=0.
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk_reset_vals();
    end
    reset = 1'b0;
    kk = 0;
  endtask

  // Checks cycles up to k=last. lit: digits expected to light;
  // nibs: shadow value in force; dpm: shadow dp_in.
  task automatic check_to(input int last, input logic [3:0] lit,
                          input logic [15:0] nibs, input logic [3:0] dpm);
    int n;
    int c;
    logic on;
    logic [15:0] nv;
    logic [3:0] e_an;
    logic e_dp;
    while (kk < last) begin
      @(negedge clk);
      kk++;
      n  = ((kk - 1) / DWELL) % 4;
      c  = (kk - 1) % DWELL;
      on = (c >= GUARD) && lit[n];
      nv = nibs >> (4 * n);
      e_an = on ? ~(4'b0001 << n) : 4'b1111;
      e_dp = on ? ~dpm[n] : 1'b1;
      chk("an",  16'(an),         16'(e_an));
      chk("nib", 16'(nibble),     16'(nv[3:0]));
      chk("dp",  16'(dp),         16'(e_dp));
      chk("sel", 16'(digit_sel),  16'(n));
      chk("fd",  16'(frame_done), 16'((kk % FRAME) == 0));
    end
  endtask

  initial begin
    value = 16'h1234; dig_en = 4'b1111; dp_in = 4'b0000; lz_blank = 1'b0;
    do_reset(3);
    chk_reset_vals();

    // Frame 1: 1234, value changed mid-frame during digit 1.
    check_to(1, 4'b1111, 16'h0000, 4'b0000);
    check_to(12, 4'b1111, 16'h1234, 4'b0000);
    value = 16'hABCD;
    check_to(33, 4'b1111, 16'h1234, 4'b0000);
    check_to(40, 4'b1111, 16'hABCD, 4'b0000);

    // Leading-zero blanking: 0040 lights digits 1 and 0 only.
    value = 16'h0040; lz_blank = 1'b1;
    check_to(65, 4'b1111, 16'hABCD, 4'b0000);
    check_to(90, 4'b0011, 16'h0040, 4'b0000);
    value = 16'h0000;
    check_to(97, 4'b0011, 16'h0040, 4'b0000);
    check_to(120, 4'b0001, 16'h0000, 4'b0000);

    // Decimal point on digit 2, first enabled, then with digit 2 disabled.
    value = 16'h1234; lz_blank = 1'b0; dp_in = 4'b0100;
    check_to(129, 4'b0001, 16'h0000, 4'b0000);
    check_to(150, 4'b1111, 16'h1234, 4'b0100);
    dig_en = 4'b1011;
    check_to(161, 4'b1111, 16'h1234, 4'b0100);
    check_to(212, 4'b1011, 16'h1234, 4'b0100);

    // Single-cycle reset at relative k=20 of a frame, new data ready.
    value = 16'hABCD; dig_en = 4'b1111; dp_in = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    kk++;
    chk_reset_vals();
    reset = 1'b0;
    kk = 0;
    check_to(1, 4'b1111, 16'h0000, 4'b0000);
    check_to(40, 4'b1111, 16'hABCD, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It latches a 16-bit value once per frame and walks the four digits with a fixed dwell time. For each digit it emits the 4-bit nibble for the downstream hex-to-7-segment decoder, together with the active-low anode and decimal-point lines. It sits between the game's score/status logic and the segment decoder at the board top level.

## Interface
Parameters:
- DWELL, 65536: clock cycles each digit is selected (100 MHz gives about 381 Hz frame rate); must be ≥ 4.
- GUARD, 256: cycles at the start of each dwell with all anodes off (anti-ghosting); must be ≥ 2 and < DWELL.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- value  in  16  four hex digits; digit i = value[4i+3:4i], digit 0 rightmost.
- dig_en  in  4  per-digit enable; 0 forces that digit dark.
- dp_in  in  4  per-digit decimal point, active-high.
- lz_blank  in  1  1 = suppress leading zeros.
- nibble  out  4  hex nibble for the segment decoder.
- an  out  4  anode enables, active-low.
- dp  out  1  decimal point, active-low.
- digit_sel  out  2  index of the currently scanned digit.
- frame_done  out  1  one-cycle pulse at the end of each full 4-digit frame.

## Operation
- Dwell counter cnt runs 0..DWELL-1 and wraps. On wrap, digit index d advances 0→1→2→3→0.
- Shadow registers capture value, dig_en, dp_in and lz_blank on every cycle where cnt==0 and d==0. This includes the first cycle after reset deasserts. Inputs changing mid-frame have no visible effect until the next frame.
- Digit d is lit when all of the following hold:
  - cnt ≥ GUARD;
  - shadow dig_en[d]==1;
  - not leading-zero-blanked.
- Leading-zero rule: with lz_blank=1, digit d>0 is blanked when the shadow nibbles d..3 are all zero. Digit 0 is never LZ-blanked.
- When lit: an = ~(1<<d), dp = ~shadow dp_in[d]. Otherwise an = 4'b1111 and dp = 1.
- nibble = shadow nibble d, regardless of lit state.
- frame_done asserts when cnt==DWELL-1 and d==3.
- Reset values:
  - cnt=0, d=0, all shadows 0;
  - an=4'b1111, dp=1, nibble=0, digit_sel=0, frame_done=0.
- Reset asserted mid-frame: the next cycle shows reset values and the scan restarts at digit 0. Nothing from the old shadow appears afterwards.

## Timing
- All outputs are registered and reflect the state (cnt, d, shadow) of the previous cycle, i.e. 1-cycle latency.
- Shadow load and the output register sample on the same edge. The stale-shadow cycle always falls inside GUARD, so it is never visible on an.
- Taking the first post-reset cycle as k=0 (cnt=0):
  - digit 0 an is low for k = GUARD+1 .. DWELL;
  - digit n an is low for k = n·DWELL+GUARD+1 .. (n+1)·DWELL.
- Frame period is 4·DWELL cycles. frame_done is high at k = 4·DWELL, then every 4·DWELL cycles.
- At most one an bit is low in any cycle. an changes only at dwell boundaries and at cnt==GUARD.

## Structure
- Shared package disp_pkg holds:
  - NUM_DIGITS = 4;
  - digit index typedef (2-bit);
  - AN_OFF = 4'b1111;
  - DP_OFF = 1'b1.
- One natural sub-module, refresh_prescaler: the dwell counter, emitting a wrap pulse and a guard flag.
- The leading-zero mask and anode decode are combinational in the parent.
- hex7seg is instantiated by the top level downstream of nibble, not inside this block.

## Test plan
Bench parameters: DWELL=8, GUARD=2.
- Reset held 3 cycles → an=4'b1111, dp=1, nibble=0, digit_sel=0, frame_done=0 throughout.
- value=16'h1234, dig_en=4'b1111, lz_blank=0 →
  - k=3..8: an=4'b1110, nibble=4;
  - k=9..10: an=4'b1111;
  - k=11..16: an=4'b1101, nibble=3;
  - k=27..32: an=4'b0111, nibble=1;
  - frame_done high only at k=32.
- lz_blank=1 →
  - value=16'h0040: digits 3 and 2 stay dark; digit 1 lit with nibble 4; digit 0 lit with nibble 0.
  - value=16'h0000: only digit 0 lit, with nibble 0.
- value changed from 16'h1234 to 16'hABCD at k=12 (during digit 1) → digits 1–3 of frame 1 still show 3, 2, 1; frame 2 digit 0 shows nibble D at k=35.
- dp_in=4'b0100, dig_en=4'b1011 → dp=0 only at k=19..24 (digit 2); digit 2 an bit is high for the whole dwell, and dp stays 1 during digit 2.
- Reset asserted at k=20 for 1 cycle → k=21 shows reset values; scan restarts with digit 0 lit 3 cycles after reset deasserts, using the newly latched value.
